// File: rtl/dmem_ram_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ram_pkg
//   Shared definitions for the dmem_ram data memory slice:
//     - clear-FSM state encodings (ST_IDLE = 1'b0, ST_CLEAR = 1'b1)
//     - default parameter constants for the memory
//     - bytes_of(): number of byte lanes in a data word
//   Optional feature macro used by this slice: DMEM_PARITY_EN.
// -----------------------------------------------------------------------------
package dmem_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dmem_state_e;

  localparam int DMEM_DATA_W    = 32;
  localparam int DMEM_ADDR_W    = 11;
  localparam int DMEM_DEPTH     = 2048;
  localparam int DMEM_PORT_W    = 8;
  localparam int DMEM_PORT_ADDR = 0;

  // Byte lanes per word (BYTES = DATA_W/8).
  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_clear_fsm.sv
// -----------------------------------------------------------------------------
// dmem_clear_fsm
//   Reset-clear sequencer for dmem_ram. After reset it walks clr_ptr from 0 to
//   DEPTH-1, requesting one zero write per cycle, then settles in IDLE.
//   Ports:
//     clk       in   clock, posedge
//     rst       in   synchronous active-high reset; (re)starts the clear at 0
//     busy      out  1 while the clear is in progress
//     clr_we    out  clear write strobe for this cycle
//     clr_addr  out  word address being cleared
//   Related feature macro in this slice: DMEM_PARITY_EN (not used here).
// -----------------------------------------------------------------------------
module dmem_clear_fsm
  import dmem_ram_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    if (state_q == ST_CLEAR) begin
      // The array is left untouched while rst is still held.
      clr_we = !rst;
      if (clr_ptr_q == LAST_ADDR) begin
        state_d   = ST_IDLE;
        clr_ptr_d = '0;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
//   Single-port data memory for the MIPS MEM stage: byte-enabled synchronous
//   writes, registered reads with a one-cycle valid strobe, and a registered
//   mirror of the low PORT_W bits of word PORT_ADDR for the board I/O port.
//   After reset the whole array is zeroed one word per cycle (busy=1).
//   Ports:
//     clk, rst   clock / synchronous active-high reset
//     addr       word address (ADDR_W)
//     wdata, wen, be   write data, write enable, byte enables
//     ren        read request
//     rdata      registered read data, held while rvalid=0
//     rvalid     one-cycle read-valid pulse
//     port_out   mem[PORT_ADDR][PORT_W-1:0]
//     busy       clear in progress; accesses ignored
//     par_err    parity error on the current rdata
//   Config macro: DMEM_PARITY_EN -- stores an even-parity bit per byte and
//   drives par_err; when undefined par_err is tied to 0.
// -----------------------------------------------------------------------------
module dmem_ram
  import dmem_ram_pkg::*;
#(
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DEPTH     = DMEM_DEPTH,
  parameter int PORT_W    = DMEM_PORT_W,
  parameter int PORT_ADDR = DMEM_PORT_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     wen,
  input  logic [DATA_W/8-1:0]      be,
  input  logic                     ren,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic [PORT_W-1:0]        port_out,
  output logic                     busy,
  output logic                     par_err
);

  localparam int BYTES = bytes_of(DATA_W);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  dmem_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Access qualification: only IDLE (not busy, not in reset) accepts accesses.
  logic in_range;
  logic acc_we;
  logic acc_re;

  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign acc_we   = !rst && !busy && wen && in_range;
  assign acc_re   = !rst && !busy && ren;

  // Single write port shared by the clear sequencer and the user.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_be;

  assign mem_we    = clr_we || acc_we;
  assign mem_addr  = clr_we ? clr_addr : addr;
  assign mem_wdata = clr_we ? '0 : wdata;
  assign mem_be    = clr_we ? '1 : be;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (mem_we && mem_be[i]) begin
        mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Registered read. Non-blocking update of mem_q makes a same-address
  // read/write return the old word (read-first).
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= acc_re;
      if (acc_re) begin
        rdata_q <= in_range ? mem_q[addr] : '0;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

  // port_out shadows the low bits of PORT_ADDR; merging against the shadow
  // itself avoids a second read of the array. The clear write (data 0, all
  // bytes enabled) naturally forces it to zero.
  logic [PORT_W-1:0] port_q, port_d;

  for (genvar gi = 0; gi < PORT_W; gi++) begin : g_port_merge
    assign port_d[gi] = mem_be[gi / 8] ? mem_wdata[gi] : port_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port_q <= '0;
    end else if (mem_we && (mem_addr == ADDR_W'(PORT_ADDR))) begin
      port_q <= port_d;
    end
  end

  assign port_out = port_q;

`ifdef DMEM_PARITY_EN
  // One even-parity bit per byte, written together with the byte.
  logic [BYTES-1:0] par_mem_q [DEPTH];
  logic [BYTES-1:0] par_wbits;
  logic [BYTES-1:0] par_rcalc;
  logic [BYTES-1:0] rpar_q;
  logic [BYTES-1:0] rbe_q;
  logic             rchk_q;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_par
    assign par_wbits[gi] = ^mem_wdata[8*gi +: 8];
    assign par_rcalc[gi] = ^rdata_q[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (mem_we && mem_be[i]) begin
        par_mem_q[mem_addr][i] <= par_wbits[i];
      end
    end
  end

  // Stored parity and byte mask are registered with rdata; the check is done
  // on the registered word so the array keeps a plain registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpar_q <= '0;
      rbe_q  <= '0;
      rchk_q <= 1'b0;
    end else begin
      rchk_q <= acc_re && in_range;
      if (acc_re && in_range) begin
        rpar_q <= par_mem_q[addr];
        rbe_q  <= be;
      end
    end
  end

  assign par_err = rchk_q && |(rbe_q & (rpar_q ^ par_rcalc));
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ram.sv
module tb_dmem_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  be;
  logic        ren;

  logic [31:0] rdata,   rdata_r;
  logic        rvalid,  rvalid_r;
  logic [7:0]  port_out, port_out_r;
  logic        busy,    busy_r;
  logic        par_err, par_err_r;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Default-parameter memory (DEPTH 2048, PORT_ADDR 0).
  dmem_ram dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wen(wen), .be(be),
    .ren(ren), .rdata(rdata), .rvalid(rvalid), .port_out(port_out),
    .busy(busy), .par_err(par_err)
  );

  // Partially populated memory for the out-of-range case.
  dmem_ram #(.DEPTH(1000)) dut_r (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wen(wen), .be(be),
    .ren(ren), .rdata(rdata_r), .rvalid(rvalid_r), .port_out(port_out_r),
    .busy(busy_r), .par_err(par_err_r)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick;
      n++;
    end
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wen = 1'b1; ren = 1'b0;
    tick;
    wen = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a);
    addr = a; be = 4'hF; ren = 1'b1; wen = 1'b0;
    tick;
    ren = 1'b0;
  endtask

  int n;
  logic saw_rv;

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wen = 1'b0; be = 4'h0; ren = 1'b0;
    tick;
    tick;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_port", {24'd0, port_out}, 32'h0);
    chk("rst_parerr", {31'd0, par_err}, 32'd0);
    rst = 1'b0;
    wait_idle(n);
    chk("busy_len0", n, 32'd2048);
    chk("r_busy_done", {31'd0, busy_r}, 32'd0);

    // 1. preload word 5, pulse reset, word 5 must read back zero
    wr(11'd5, 32'hDEADBEEF, 4'hF);
    rd(11'd5);
    chk("pre_rd", rdata, 32'hDEADBEEF);
    chk("pre_rvalid", {31'd0, rvalid}, 32'd1);
    tick;
    chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);
    chk("rdata_hold", rdata, 32'hDEADBEEF);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    wait_idle(n);
    chk("busy_len1", n, 32'd2048);
    rd(11'd5);
    chk("clr_rd5", rdata, 32'h0);

    // 2. byte enables
    wr(11'd3, 32'hAABBCCDD, 4'hF);
    wr(11'd3, 32'h11223344, 4'b0101);
    rd(11'd3);
    chk("be_rvalid", {31'd0, rvalid}, 32'd1);
    chk("be_rd", rdata, 32'hAA22CC44);
    wr(11'd3, 32'hFFFFFFFF, 4'b0000);
    rd(11'd3);
    chk("be0_noop", rdata, 32'hAA22CC44);

    // 3. read-during-write (read-first), then back-to-back read
    wr(11'd7, 32'h1, 4'hF);
    addr = 11'd7; wdata = 32'h2; be = 4'hF; wen = 1'b1; ren = 1'b1;
    tick;
    wen = 1'b0;
    chk("rdw_old", rdata, 32'h1);
    chk("rdw_rvalid", {31'd0, rvalid}, 32'd1);
    tick;
    ren = 1'b0;
    chk("rdw_new", rdata, 32'h2);
    chk("b2b_rvalid", {31'd0, rvalid}, 32'd1);

    // 4. memory-mapped port
    wr(11'd0, 32'h000000A5, 4'hF);
    chk("port_wr", {24'd0, port_out}, 32'hA5);
    wr(11'd0, 32'h12345600, 4'b1110);
    chk("port_keep", {24'd0, port_out}, 32'hA5);
    rd(11'd0);
    chk("port_word", rdata, 32'h123456A5);

    // 5. reset mid-clear; writes/reads during busy leave no trace
    rst = 1'b1;
    tick;
    rst = 1'b0;
    repeat (100) tick;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    addr = 11'd0; wdata = 32'h5A5A5A5A; be = 4'hF; wen = 1'b1; ren = 1'b1;
    saw_rv = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick;
      n++;
      if (busy === 1'b1 && rvalid !== 1'b0) saw_rv = 1'b1;
    end
    wen = 1'b0; ren = 1'b0;
    chk("busy_len2", n, 32'd2048);
    chk("busy_norv", {31'd0, saw_rv}, 32'd0);
    chk("busy_port", {24'd0, port_out}, 32'h0);
    rd(11'd0);
    chk("busy_nowr", rdata, 32'h0);

    // 6. out of range on the 1000-word instance
    wr(11'd1500, 32'h00000077, 4'hF);
    rd(11'd1500);
    chk("oor_rdata", rdata_r, 32'h0);
    chk("oor_rvalid", {31'd0, rvalid_r}, 32'd1);
    chk("inr_rdata", rdata, 32'h77);
    chk("oor_parerr", {31'd0, par_err_r}, 32'd0);

`ifdef DMEM_PARITY_EN
    wr(11'd3, 32'h0F0F0F0F, 4'hF);
    rd(11'd3);
    chk("par_clean", {31'd0, par_err}, 32'd0);
    dut.mem_q[3][0] = ~dut.mem_q[3][0];
    rd(11'd3);
    chk("par_rvalid", {31'd0, rvalid}, 32'd1);
    chk("par_err", {31'd0, par_err}, 32'd1);
    tick;
    chk("par_idle", {31'd0, par_err}, 32'd0);
`else
    rd(11'd3);
    chk("par_tied", {31'd0, par_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
